// File: rtl/ex_muldiv_if.sv
// EX-stage RV32M request/response bundle between the pipeline control and ex_muldiv_unit.
interface ex_muldiv_if #(
  parameter int unsigned XLEN = 32
);
  logic            valid_i;
  logic [2:0]      funct3_i;
  logic [1:0]      ForwardA_i;
  logic [1:0]      ForwardB_i;
  logic [XLEN-1:0] RS1data_i;
  logic [XLEN-1:0] RS2data_i;
  logic [XLEN-1:0] MEM_ALUResult_i;
  logic [XLEN-1:0] WB_WriteData_i;
  logic            flush_i;
  logic            stall_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output valid_i, funct3_i, ForwardA_i, ForwardB_i, RS1data_i, RS2data_i,
           MEM_ALUResult_i, WB_WriteData_i, flush_i,
    input  stall_o, done_o, result_o
  );

  modport slave (
    input  valid_i, funct3_i, ForwardA_i, ForwardB_i, RS1data_i, RS2data_i,
           MEM_ALUResult_i, WB_WriteData_i, flush_i,
    output stall_o, done_o, result_o
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit in EX with operand forwarding and pipeline stall.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiplier for MUL* ops.
module ex_muldiv_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ITER_CNT_W = 6
) (
  input  logic         clk_i,
  input  logic         rst_i,
  ex_muldiv_if.slave   bus
);
  localparam int unsigned W2 = 2 * XLEN;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [ITER_CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]            op_q, op_d;
  logic                  neg_q, neg_d;
  logic [XLEN-1:0]       opnd_q, opnd_d;
  logic [XLEN-1:0]       result_q, result_d;
  logic [W2-1:0]         acc_q, acc_d;
  logic                  stall_c;

  logic [XLEN-1:0] src_a, src_b, a_mag, b_mag, special_res;
  logic            is_div, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;

  // Forwarding muxes: 10 = MEM ALU result, 01 = WB write data, else register file
  always_comb begin
    case (bus.ForwardA_i)
      2'b10:   src_a = bus.MEM_ALUResult_i;
      2'b01:   src_a = bus.WB_WriteData_i;
      default: src_a = bus.RS1data_i;
    endcase
    case (bus.ForwardB_i)
      2'b10:   src_b = bus.MEM_ALUResult_i;
      2'b01:   src_b = bus.WB_WriteData_i;
      default: src_b = bus.RS2data_i;
    endcase
  end

  // Operand decode; unsigned sides never see a negative sign
  always_comb begin
    is_div   = bus.funct3_i[2];
    a_sgn    = is_div ? !bus.funct3_i[0] : (bus.funct3_i[1:0] != 2'b11);
    b_sgn    = is_div ? !bus.funct3_i[0] : !bus.funct3_i[1];
    a_neg    = a_sgn & src_a[XLEN-1];
    b_neg    = b_sgn & src_b[XLEN-1];
    a_mag    = a_neg ? -src_a : src_a;
    b_mag    = b_neg ? -src_b : src_b;
    div_zero = is_div && (src_b == '0);
    div_ovf  = is_div && !bus.funct3_i[0] && (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (&src_b);
    if (div_zero) special_res = bus.funct3_i[1] ? src_a : '1;
    else          special_res = bus.funct3_i[1] ? '0 : src_a;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [W2-1:0] fast_a, fast_b, fast_prod;
  logic [XLEN-1:0] fast_res;
  always_comb begin
    fast_a    = {{XLEN{a_neg}}, src_a};
    fast_b    = {{XLEN{b_neg}}, src_b};
    fast_prod = fast_a * fast_b;
    fast_res  = (bus.funct3_i[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[W2-1:XLEN];
  end
`endif

  // One iteration: shift-add multiply step or restoring divide step
  logic [XLEN:0]   mul_sum, div_trial;
  logic [W2-1:0]   step, p_fix;
  logic [XLEN-1:0] div_sel, fin_res;
  always_comb begin
    mul_sum   = {1'b0, acc_q[W2-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_trial = acc_q[W2-1:XLEN-1] - {1'b0, opnd_q};
    if (op_q[2]) begin
      step = div_trial[XLEN] ? {acc_q[W2-2:0], 1'b0}
                             : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      step = {mul_sum, acc_q[XLEN-1:1]};
    end
    p_fix   = neg_q ? -step : step;
    div_sel = op_q[1] ? step[W2-1:XLEN] : step[XLEN-1:0];
    if (op_q[2])               fin_res = neg_q ? -div_sel : div_sel;
    else if (op_q[1:0] == '0)  fin_res = p_fix[XLEN-1:0];
    else                       fin_res = p_fix[W2-1:XLEN];
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;
    stall_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.valid_i && !bus.flush_i) begin
          stall_c = 1'b1;
          op_d    = bus.funct3_i;
          neg_d   = (is_div && bus.funct3_i[1]) ? a_neg : (a_neg ^ b_neg);
          cnt_d   = '0;
          if (div_zero || div_ovf) begin
            result_d = special_res;
            state_d  = S_DONE;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!is_div) begin
            result_d = fast_res;
            state_d  = S_DONE;
`endif
          end else begin
            opnd_d  = is_div ? b_mag : a_mag;
            acc_d   = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        stall_c = 1'b1;
        if (bus.flush_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step;
          cnt_d = cnt_q + ITER_CNT_W'(1);
          if (cnt_q == ITER_CNT_W'(XLEN - 1)) begin
            result_d = fin_res;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign bus.stall_o  = stall_c;
  assign bus.done_o   = (state_q == S_DONE);
  assign bus.result_o = result_q;
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- EX-stage RV32M execution unit, sitting directly downstream of the forwarding unit.
- Consumes ForwardA/ForwardB selects; picks operands from ID/EX register data, MEM-stage ALU result or WB write-back data.
- Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU iteratively; holds the front of the pipeline via a stall output until the result is ready for the EX/MEM register.

Parameters:
- XLEN, 32, operand/result width.
- ITER_CNT_W, 6, width of the iteration counter; must hold XLEN.

Ports:
- clk_i  input  1  pipeline clock
- rst_i  input  1  asynchronous reset, active-low
- valid_i  input  1  M-extension instruction present in EX (opcode 0110011, funct7 0000001)
- funct3_i  input  3  M operation select
- ForwardA_i  input  2  00 = RS1data_i, 10 = MEM_ALUResult_i, 01 = WB_WriteData_i, 11 = RS1data_i
- ForwardB_i  input  2  same encoding, applied to rs2
- RS1data_i  input  XLEN  ID/EX rs1 value
- RS2data_i  input  XLEN  ID/EX rs2 value
- MEM_ALUResult_i  input  XLEN  EX/MEM ALU result
- WB_WriteData_i  input  XLEN  MEM/WB write-back data
- flush_i  input  1  abort the current operation
- stall_o  output  1  hold PC, IF/ID and ID/EX; insert bubble into EX/MEM
- done_o  output  1  result_o valid this cycle
- result_o  output  XLEN  operation result

Behaviour:
- Reset (rst_i=0, asynchronous): state IDLE; stall_o=0, done_o=0, result_o=0; counter and all datapath registers cleared.
- States:
  - IDLE -> BUSY on valid_i & !flush_i.
  - IDLE -> DONE directly for div-by-zero or signed overflow.
  - BUSY -> DONE when the counter reaches XLEN-1.
  - DONE -> IDLE unconditionally.
- Operand capture: forwarded operands are latched on the accept edge only; later changes to forwarding inputs are ignored.
- stall_o timing:
  - Combinationally 1 in IDLE when valid_i & !flush_i, so the accept cycle itself stalls.
  - 1 throughout BUSY.
  - 0 in DONE, so the pipeline advances on the DONE cycle.
- Latency: accept edge T; XLEN BUSY cycles; DONE in cycle T+XLEN+1.
- done_o=1 only in DONE. result_o holds its value until the next DONE or reset.
- Multiply: radix-2 shift-add over |a|, |b| into a 2*XLEN product, with sign fix-up at the end.
  - MUL returns product[XLEN-1:0].
  - MULH (signed x signed), MULHSU (rs1 signed, rs2 unsigned) and MULHU (unsigned x unsigned) return product[2*XLEN-1:XLEN].
- Divide: restoring division over |a|, |b|.
  - Quotient is negated when the signs differ (DIV only).
  - Remainder takes the sign of the dividend (REM only).
- Special cases (resolved in IDLE, one cycle to DONE):
  - Divisor 0: DIV/DIVU return all-ones; REM/REMU return the dividend.
  - DIV with 0x80000000 / 0xFFFFFFFF returns 0x80000000; REM returns 0.
- Back-to-back: a new valid_i in the cycle after DONE is accepted normally from IDLE.
- flush_i in BUSY or DONE: next state IDLE, done_o=0, stall_o=0 next cycle; result_o is not updated.
- flush_i takes priority over valid_i.

Optional Feature:
- MULDIV_FAST_MUL_EN
  - Defined: MUL* uses a single-cycle XLEN x XLEN combinational multiplier. Path is IDLE -> DONE, stall_o high on the accept cycle only, DONE at T+1. Divide timing is unchanged.
  - Undefined: all operations use the iterative datapath with the latency above.

Test Plan:
- MUL, ForwardA=00, ForwardB=00, rs1=7, rs2=6 -> stall_o high 33 cycles; done_o at T+33 with result_o=42.
- DIV, ForwardA=10 (MEM_ALUResult_i=-20), ForwardB=01 (WB_WriteData_i=3), RS1/RS2=0 -> result_o=0xFFFFFFFA (-6). Repeat as REM -> 0xFFFFFFFE (-2).
- DIVU by zero, rs1=0x1234 -> done at T+1, result 0xFFFFFFFF. REMU by zero -> 0x1234.
- DIV 0x80000000 / 0xFFFFFFFF -> done at T+1, result 0x80000000. REM -> 0.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0x2 -> 0xFFFFFFFF.
- Reset asserted 10 cycles into BUSY -> stall_o/done_o/result_o=0 immediately. Separately, flush_i at cycle 5 of BUSY -> IDLE next cycle, no done_o. A following MUL 3x3 returns 9 normally.
